// File: rtl/core_alu_sched_if.sv
// ---------------------------------------------------------------------------
// core_alu_sched_if
// Upstream instruction channel into the ALU issue scheduler.
//
// Handshake: the master holds in_valid and the payload (in_dec, in_ra, in_rb,
// in_rb_used). The slave raises in_ready when it can take the payload. One
// instruction transfers on every rising clock edge where in_valid and
// in_ready are both high. in_ready may depend combinationally on slave-side
// inputs such as flush and writeback, but never on in_valid.
//
// Signals:
//   in_valid    master -> slave  decoded ALU instruction offered
//   in_ready    slave  -> master instruction accepted on this edge
//   in_dec      master -> slave  decoded instruction (insn_decode layout)
//   in_ra       master -> slave  source register a index
//   in_rb       master -> slave  source register b index
//   in_rb_used  master -> slave  source b is a register (not an immediate)
// ---------------------------------------------------------------------------
interface core_alu_sched_if #(
    parameter int DEC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DEC_W-1:0] in_dec;
    logic [3:0]       in_ra;
    logic [3:0]       in_rb;
    logic             in_rb_used;

    modport master (
        output in_valid,
        output in_dec,
        output in_ra,
        output in_rb,
        output in_rb_used,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_dec,
        input  in_ra,
        input  in_rb,
        input  in_rb_used,
        output in_ready
    );
endinterface

// File: rtl/core_alu_sched.sv
// ---------------------------------------------------------------------------
// core_alu_sched
// Single-entry ALU issue buffer with a register scoreboard.
//
// An accepted instruction waits in a one-deep buffer until none of its
// source registers (ra, rb when used) nor its destination rd has a write
// pending. It then issues to the ALU with a one-cycle alu_start strobe and
// its rd is marked busy until the matching writeback arrives. A writeback
// in the same cycle is visible to the hazard check, so a waiting instruction
// issues in the writeback cycle itself.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   up          instruction channel (core_alu_sched_if.slave)
//   flush       drop any buffered, not yet issued instruction
//   wb_valid    a writeback to wb_rd completes this cycle
//   wb_rd       register index being written back
//   alu_start   ALU issue strobe
//   alu_dec     buffered instruction presented to the ALU
//   busy_mask   scoreboard, bit r set = write to r pending
//   stall_cnt   saturating count of hazard-stall cycles
//   dbg_state   buffer state (0 = EMPTY, 1 = FULL)
//
// Instruction encoding (16 bits): op[15:12], data.rd[11:8], data.imm[7:0].
// The interface DEC_W parameter must equal $bits(insn_decode).
// ---------------------------------------------------------------------------
module core_alu_sched #(
    parameter int W    = 16,   // register data width, not used by this datapath
    parameter int NREG = 16    // tracked registers; indices are 4 bits
) (
    input  logic               clk,
    input  logic               rst_n,
    core_alu_sched_if.slave    up,
    input  logic               flush,
    input  logic               wb_valid,
    input  logic [3:0]         wb_rd,
    output logic               alu_start,
    output logic [15:0]        alu_dec,
    output logic [NREG-1:0]    busy_mask,
    output logic [15:0]        stall_cnt,
    output logic               dbg_state
);

    typedef struct packed {
        logic [3:0] rd;
        logic [7:0] imm;
    } insn_data;

    typedef struct packed {
        logic [3:0] op;
        insn_data   data;
    } insn_decode;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    // Register indices are 4 bits, so more than 16 registers cannot be named.
    if (W < 1 || NREG > 16 || NREG < 1) begin : g_bad_params
        $error("core_alu_sched: W must be >= 1 and NREG must be 1..16");
    end

    buf_state_t state;
    insn_decode buf_dec;
    logic [3:0] buf_ra;
    logic [3:0] buf_rb;
    logic       buf_rb_used;

    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] issue_set;
    logic [NREG-1:0] eff_busy;
    logic            full;
    logic            hazard;
    logic            accept;

    assign full = (state == FULL);

    // Writeback this cycle already counts as free for the hazard check.
    always_comb begin
        wb_clr    = '0;
        issue_set = '0;
        if (wb_valid) begin
            wb_clr = NREG'(1) << wb_rd;
        end
        if (alu_start) begin
            issue_set = NREG'(1) << buf_dec.data.rd;
        end
    end

    assign eff_busy = busy_mask & ~wb_clr;

    assign hazard = full && (eff_busy[buf_ra]
                             || (buf_rb_used && eff_busy[buf_rb])
                             || eff_busy[buf_dec.data.rd]);

    assign alu_start   = full && !hazard && !flush;
    assign alu_dec     = buf_dec;
    assign up.in_ready = !flush && (!full || alu_start);
    assign accept      = up.in_valid && up.in_ready;
    assign dbg_state   = state;

    // Buffer FSM. Accept wins over issue so a back-to-back stream reloads
    // the buffer in the same edge it issues, giving one instruction/cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            buf_dec     <= '0;
            buf_ra      <= '0;
            buf_rb      <= '0;
            buf_rb_used <= 1'b0;
        end else begin
            if (flush) begin
                state <= EMPTY;
            end else if (accept) begin
                state       <= FULL;
                buf_dec     <= up.in_dec;
                buf_ra      <= up.in_ra;
                buf_rb      <= up.in_rb;
                buf_rb_used <= up.in_rb_used;
            end else if (alu_start) begin
                state <= EMPTY;
            end
        end
    end

    // Scoreboard. Set is applied after clear so an issue to a register
    // that is being written back this cycle leaves the bit pending.
    // A writeback to an idle register clears an already-clear bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= (busy_mask & ~wb_clr) | issue_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/core_alu_sched.md
CORE_ALU_SCHED -- requirements
Module: core_alu_sched

Interface
REQ-001 SHALL have parameter W, default 16, meaning register data width (informational; not used by this block's datapath).
REQ-002 SHALL have parameter NREG, default 16, meaning number of architectural registers tracked; the scoreboard width equals NREG, register index width is 4.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  decoded ALU instruction offered.
REQ-006 SHALL have port in_ready  out  1  instruction accepted when in_valid && in_ready at a clock edge.
REQ-007 SHALL have port in_dec  in  $bits(insn_decode)  decoded instruction (insn_decode struct).
REQ-008 SHALL have port in_ra  in  4  index of source register a.
REQ-009 SHALL have port in_rb  in  4  index of source register b.
REQ-010 SHALL have port in_rb_used  in  1  1 when source b is read (not immediate).
REQ-011 SHALL have port flush  in  1  discard any buffered, unissued instruction.
REQ-012 SHALL have port wb_valid  in  1  a writeback to register wb_rd completes this cycle.
REQ-013 SHALL have port wb_rd  in  4  register index being written back.
REQ-014 SHALL have port alu_start  out  1  ALU issue strobe.
REQ-015 SHALL have port alu_dec  out  $bits(insn_decode)  instruction presented to the ALU.
REQ-016 SHALL have port busy_mask  out  NREG (hword)  scoreboard: bit r set = write to r pending.
REQ-017 SHALL have port stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-018 SHALL hold one instruction in a single-entry buffer with two states: EMPTY and FULL.
REQ-019 SHALL define hazard = FULL && (eff[ra] || (rb_used && eff[rb]) || eff[rd]), where eff = busy_mask with bit wb_rd cleared when wb_valid, and rd = alu_dec.data.rd.
REQ-020 SHALL drive alu_start = FULL && !hazard && !flush combinationally; alu_dec SHALL always equal the buffer contents.
REQ-021 SHALL drive in_ready = !flush && (EMPTY || alu_start).
REQ-022 Transitions: EMPTY->FULL on accept; FULL->EMPTY on alu_start without accept; FULL->FULL on alu_start with accept (buffer reloaded, back-to-back issue, one instruction per cycle); FULL->FULL on hazard (buffer held); any->EMPTY on flush.
REQ-023 SHALL set busy_mask[rd] at the edge after alu_start is high.
REQ-024 SHALL clear busy_mask[wb_rd] at the edge where wb_valid is high.
REQ-025 On simultaneous set and clear of the same bit, set SHALL win (bit ends 1).
REQ-026 wb_valid for a register whose busy bit is 0 SHALL be ignored.
REQ-027 flush SHALL NOT alter busy_mask; writes already issued still complete and clear their bits.
REQ-028 stall_cnt SHALL increment by 1 on each edge where FULL && hazard && !flush, saturating at 16'hFFFF.
REQ-029 Issue-to-ALU latency: an instruction accepted at edge N with no hazard SHALL produce alu_start in cycle N+1.

Reset
REQ-030 While rst_n is low, asynchronously: state EMPTY, busy_mask 0, stall_cnt 0, buffer contents unspecified; therefore in_ready = 1 and alu_start = 0.
REQ-031 Reset asserted mid-operation SHALL discard the buffered instruction and all pending busy bits; no alu_start after release until a new accept.

Verification
REQ-032 Independent stream: three instructions rd=1,2,3, sources r4/r5, wb never -> alu_start high cycles N+1..N+3, busy_mask 16'h000E, stall_cnt 0.
REQ-033 RAW stall: issue rd=2; next ra=2; wb_valid wb_rd=2 three cycles later -> second instruction held; issues in the wb cycle (bypass clear); busy_mask[2] stays 1 (set wins); stall_cnt = 2.
REQ-034 Immediate source: rb=2 with in_rb_used=0 and busy[2]=1 -> no stall, issues next cycle.
REQ-035 Flush: buffer FULL stalled on busy[7], flush pulse -> alu_start never high for that instruction, state EMPTY, busy_mask unchanged, in_ready 0 in the flush cycle and 1 after.
REQ-036 Reset mid-stall: busy_mask 16'h0081, FULL, rst_n low one cycle -> busy_mask 0, stall_cnt 0, in_ready 1, alu_start 0.
